// File: rtl/btn_count_conditioner_pkg.sv
// btn_cond_pkg: shared types and default constants for the push-button
// conditioner (btn_count_conditioner) and its synchronizer.
//
// Contents:
//   btn_state_t           - conditioner FSM state encoding
//   BTN_DEBOUNCE_DEFAULT  - default consecutive stable samples to accept an edge
//   BTN_LONG_DEFAULT      - default cycles held in PRESSED before a long press
package btn_cond_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_DB_PRESS   = 3'd1,
        ST_PRESSED    = 3'd2,
        ST_LONG       = 3'd3,
        ST_DB_RELEASE = 3'd4
    } btn_state_t;

    localparam int BTN_DEBOUNCE_DEFAULT = 4;
    localparam int BTN_LONG_DEFAULT     = 16;

endpackage

// File: rtl/btn_count_conditioner_sync2.sv
// sync2: two-flop synchronizer for a single asynchronous bit.
//
// Ports:
//   clk  in  system clock, rising edge
//   rst  in  synchronous active-high reset, both stages clear to 0
//   d    in  asynchronous input
//   q    out synchronized output (two cycles of latency)
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/btn_count_conditioner.sv
// btn_count_conditioner: synchronizes and debounces a raw push-button and
// turns each clean press into a single-cycle count_enable pulse for the
// downstream 4-bit rollover counter. A sustained hold can optionally produce
// a single-cycle clear pulse.
//
// Configuration macro: BTN_LONG_PRESS_EN
//   defined   - LONG state, hold counter and clear pulse are built
//   undefined - no LONG state / hold counter, clear tied to 0,
//               LONG_CYCLES accepted and ignored
//
// Parameters:
//   DEBOUNCE_CYCLES  stable synchronized samples to accept press/release (>=2)
//   LONG_CYCLES      cycles held in PRESSED before a long press (>=2)
//
// Ports:
//   clk           in  system clock, rising edge
//   rst           in  synchronous active-high reset
//   btn_in        in  raw button, asynchronous, active-high
//   count_enable  out registered one-cycle pulse per accepted press
//   clear         out registered one-cycle pulse per accepted long press
//   btn_level     out registered debounced button level
module btn_count_conditioner
    import btn_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT,
    parameter int LONG_CYCLES     = BTN_LONG_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic count_enable,
    output logic clear,
    output logic btn_level
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_TERM = DB_W'(DEBOUNCE_CYCLES - 1);

    logic btn_sync;

    sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (btn_sync)
    );

    btn_state_t      state_q, state_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            ce_q, ce_d;
    logic            lvl_q, lvl_d;

`ifdef BTN_LONG_PRESS_EN
    localparam int HOLD_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_TERM = HOLD_W'(LONG_CYCLES - 1);

    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              clr_q, clr_d;
    // Remembers whether DB_RELEASE was entered from LONG, so a bounce during
    // release returns there instead of re-arming the long-press timer.
    logic              ret_long_q, ret_long_d;
`else
    // LONG_CYCLES has no effect in this build; referenced only to keep it
    // visibly consumed.
    logic unused_long_cycles;
    assign unused_long_cycles = ^LONG_CYCLES;
`endif

    always_comb begin
        state_d  = state_q;
        db_cnt_d = db_cnt_q;
        ce_d     = 1'b0;
`ifdef BTN_LONG_PRESS_EN
        hold_cnt_d = hold_cnt_q;
        clr_d      = 1'b0;
        ret_long_d = ret_long_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (btn_sync) begin
                    state_d  = ST_DB_PRESS;
                    db_cnt_d = '0;
                end
            end

            ST_DB_PRESS: begin
                if (!btn_sync) begin
                    state_d  = ST_IDLE;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_TERM) begin
                    state_d  = ST_PRESSED;
                    db_cnt_d = '0;
                    ce_d     = 1'b1;
`ifdef BTN_LONG_PRESS_EN
                    hold_cnt_d = '0;
`endif
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end

            ST_PRESSED: begin
                if (!btn_sync) begin
                    state_d  = ST_DB_RELEASE;
                    db_cnt_d = '0;
`ifdef BTN_LONG_PRESS_EN
                    ret_long_d = 1'b0;
`endif
                end
`ifdef BTN_LONG_PRESS_EN
                else if (hold_cnt_q == HOLD_TERM) begin
                    state_d    = ST_LONG;
                    clr_d      = 1'b1;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
`endif
            end

`ifdef BTN_LONG_PRESS_EN
            ST_LONG: begin
                if (!btn_sync) begin
                    state_d    = ST_DB_RELEASE;
                    db_cnt_d   = '0;
                    ret_long_d = 1'b1;
                end
            end
`endif

            ST_DB_RELEASE: begin
                if (btn_sync) begin
                    // Bounce on release: resume without a pulse; the hold
                    // counter is deliberately left where it was.
                    db_cnt_d = '0;
`ifdef BTN_LONG_PRESS_EN
                    state_d = ret_long_q ? ST_LONG : ST_PRESSED;
`else
                    state_d = ST_PRESSED;
`endif
                end else if (db_cnt_q == DB_TERM) begin
                    state_d  = ST_IDLE;
                    db_cnt_d = '0;
`ifdef BTN_LONG_PRESS_EN
                    hold_cnt_d = '0;
                    ret_long_d = 1'b0;
`endif
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end

            default: begin
                state_d  = ST_IDLE;
                db_cnt_d = '0;
            end
        endcase

        // Level follows the next state so it changes on the same edge as
        // the count_enable pulse.
        lvl_d = (state_d == ST_PRESSED) || (state_d == ST_DB_RELEASE)
`ifdef BTN_LONG_PRESS_EN
             || (state_d == ST_LONG)
`endif
             ;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            db_cnt_q <= '0;
            ce_q     <= 1'b0;
            lvl_q    <= 1'b0;
`ifdef BTN_LONG_PRESS_EN
            hold_cnt_q <= '0;
            clr_q      <= 1'b0;
            ret_long_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            db_cnt_q <= db_cnt_d;
            ce_q     <= ce_d;
            lvl_q    <= lvl_d;
`ifdef BTN_LONG_PRESS_EN
            hold_cnt_q <= hold_cnt_d;
            clr_q      <= clr_d;
            ret_long_q <= ret_long_d;
`endif
        end
    end

    assign count_enable = ce_q;
    assign btn_level    = lvl_q;
`ifdef BTN_LONG_PRESS_EN
    assign clear = clr_q;
`else
    assign clear = 1'b0;
`endif

endmodule
